// File: rtl/quabo_trig_pkg.sv
// Shared trigger-path definitions: receiver FSM encoding, default qualification
// constants and a counter-width helper.
package quabo_trig_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUAL     = 3'd1,
    FIRE     = 3'd2,
    HOLD     = 3'd3,
    WAIT_LOW = 3'd4
  } ext_trig_rx_state_t;

  localparam int EXT_TRIG_MIN_WIDTH  = 4;
  localparam int EXT_TRIG_HOLDOFF    = 64;
  localparam int EXT_TRIG_ECHO_BLANK = 8;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_bits(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/trig_sync.sv
// Multi-flop synchronizer for the asynchronous trigger pad input.
module trig_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

  // Shift chain; stage 0 is the only flop that may go metastable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ext_trig_rx.sv
// External trigger receiver: synchronize, reject glitches and self-echo, emit one
// event per pulse. Optional timestamp latch built when EXT_TRIG_TIMESTAMP_EN is defined.
module ext_trig_rx
  import quabo_trig_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = EXT_TRIG_MIN_WIDTH,
  parameter int HOLDOFF     = EXT_TRIG_HOLDOFF,
  parameter int ECHO_BLANK  = EXT_TRIG_ECHO_BLANK,
  parameter int CNT_W       = 32,
  parameter int TS_W        = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_trig_in,
  input  logic             local_trig,
  input  logic             enable,
  input  logic             clear_cnt,
  output logic             trig_pulse,
  output logic [CNT_W-1:0] trig_count,
  output logic             busy,
  input  logic [TS_W-1:0]  ts_in,
  input  logic             ts_ack,
  output logic [TS_W-1:0]  trig_ts,
  output logic             trig_ts_valid,
  output logic             ts_overrun
);

  localparam int QW = cnt_bits(MIN_WIDTH);
  localparam int HW = cnt_bits(HOLDOFF);
  localparam int BW = cnt_bits(ECHO_BLANK);

  logic               w_s;
  logic               w_blanked;
  logic               w_qual;
  logic               w_fire;
  logic [BW-1:0]      r_blank_cnt;
  ext_trig_rx_state_t r_state;
  ext_trig_rx_state_t w_state_nxt;
  logic [QW-1:0]      r_qcnt;
  logic [QW-1:0]      w_qcnt_nxt;
  logic [HW-1:0]      r_hcnt;
  logic [HW-1:0]      w_hcnt_nxt;
  logic               r_trig_pulse;
  logic               r_busy;
  logic [CNT_W-1:0]   r_trig_count;

  trig_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (ext_trig_in),
    .o_q (w_s)
  );

  // Echo blanking: the pad still shows our own drive for a while after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blank_cnt <= {BW{1'b0}};
    end else if (local_trig) begin
      r_blank_cnt <= BW'(ECHO_BLANK);
    end else if (r_blank_cnt != {BW{1'b0}}) begin
      r_blank_cnt <= r_blank_cnt - BW'(1);
    end
  end

  assign w_blanked = local_trig | (r_blank_cnt != {BW{1'b0}});
  assign w_qual    = w_s & ~w_blanked;
  assign w_fire    = (r_state == FIRE);

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_qcnt  <= {QW{1'b0}};
      r_hcnt  <= {HW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_qcnt  <= w_qcnt_nxt;
      r_hcnt  <= w_hcnt_nxt;
    end
  end

  // Next-state logic for qualification, holdoff and release wait.
  always_comb begin
    w_state_nxt = r_state;
    w_qcnt_nxt  = r_qcnt;
    w_hcnt_nxt  = r_hcnt;
    if (!enable) begin
      w_state_nxt = IDLE;
      w_qcnt_nxt  = {QW{1'b0}};
      w_hcnt_nxt  = {HW{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_qual && (MIN_WIDTH == 1)) begin
            w_state_nxt = FIRE;
            w_qcnt_nxt  = {QW{1'b0}};
          end else if (w_qual) begin
            w_state_nxt = QUAL;
            w_qcnt_nxt  = QW'(1);
          end else begin
            w_qcnt_nxt  = {QW{1'b0}};
          end
        end
        QUAL: begin
          if (!w_qual) begin
            w_state_nxt = IDLE;
            w_qcnt_nxt  = {QW{1'b0}};
          end else if (r_qcnt == QW'(MIN_WIDTH - 1)) begin
            w_state_nxt = FIRE;
            w_qcnt_nxt  = {QW{1'b0}};
          end else begin
            w_qcnt_nxt  = r_qcnt + QW'(1);
          end
        end
        FIRE: begin
          w_hcnt_nxt = HW'(HOLDOFF);
          if (HOLDOFF == 0) begin
            w_state_nxt = WAIT_LOW;
          end else begin
            w_state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (r_hcnt != {HW{1'b0}}) begin
            w_hcnt_nxt = r_hcnt - HW'(1);
          end else begin
            w_hcnt_nxt = {HW{1'b0}};
          end
          if (r_hcnt <= HW'(1)) begin
            w_state_nxt = WAIT_LOW;
          end else begin
            w_state_nxt = HOLD;
          end
        end
        WAIT_LOW: begin
          if (!w_s) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT_LOW;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_qcnt_nxt  = {QW{1'b0}};
          w_hcnt_nxt  = {HW{1'b0}};
        end
      endcase
    end
  end

  // Outputs registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig_pulse <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_trig_pulse <= (w_state_nxt == FIRE);
      r_busy       <= (w_state_nxt != IDLE);
    end
  end

  // Saturating event counter; a clear coinciding with an event counts that event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig_count <= {CNT_W{1'b0}};
    end else if (w_fire) begin
      if (clear_cnt) begin
        r_trig_count <= CNT_W'(1);
      end else if (r_trig_count != {CNT_W{1'b1}}) begin
        r_trig_count <= r_trig_count + CNT_W'(1);
      end
    end else if (clear_cnt) begin
      r_trig_count <= {CNT_W{1'b0}};
    end
  end

  assign trig_pulse = r_trig_pulse;
  assign busy       = r_busy;
  assign trig_count = r_trig_count;

`ifdef EXT_TRIG_TIMESTAMP_EN
  logic [TS_W-1:0] r_trig_ts;
  logic            r_ts_valid;
  logic            r_ts_overrun;

  // Timestamp latch with valid/ack handshake; an ack in the fire cycle frees the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig_ts    <= {TS_W{1'b0}};
      r_ts_valid   <= 1'b0;
      r_ts_overrun <= 1'b0;
    end else if (w_fire) begin
      if (!r_ts_valid || ts_ack) begin
        r_trig_ts  <= ts_in;
        r_ts_valid <= 1'b1;
      end else begin
        r_ts_overrun <= 1'b1;
      end
    end else if (ts_ack) begin
      r_ts_valid <= 1'b0;
    end
  end

  assign trig_ts       = r_trig_ts;
  assign trig_ts_valid = r_ts_valid;
  assign ts_overrun    = r_ts_overrun;
`else
  logic w_unused_ts;
  assign w_unused_ts   = ^{ts_in, ts_ack};
  assign trig_ts       = {TS_W{1'b0}};
  assign trig_ts_valid = 1'b0;
  assign ts_overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_ext_trig_rx.sv
// Randomized and directed bench for ext_trig_rx against an event-level reference model.
module tb_ext_trig_rx;

  localparam int SYNC = 2;
  localparam int MW   = 4;
  localparam int HO   = 64;
  localparam int EB   = 8;
  localparam int CW   = 4;
  localparam int TW   = 48;
  localparam int unsigned CMAX = (1 << CW) - 1;
`ifdef EXT_TRIG_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ext_trig_in = 1'b0;
  logic          local_trig = 1'b0;
  logic          enable = 1'b1;
  logic          clear_cnt = 1'b0;
  logic          trig_pulse;
  logic [CW-1:0] trig_count;
  logic          busy;
  logic [TW-1:0] ts_in = '0;
  logic          ts_ack = 1'b0;
  logic [TW-1:0] trig_ts;
  logic          trig_ts_valid;
  logic          ts_overrun;

  always #5 clk = ~clk;

  ext_trig_rx #(
    .SYNC_STAGES(SYNC), .MIN_WIDTH(MW), .HOLDOFF(HO), .ECHO_BLANK(EB),
    .CNT_W(CW), .TS_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .ext_trig_in(ext_trig_in), .local_trig(local_trig),
    .enable(enable), .clear_cnt(clear_cnt), .trig_pulse(trig_pulse),
    .trig_count(trig_count), .busy(busy), .ts_in(ts_in), .ts_ack(ts_ack),
    .trig_ts(trig_ts), .trig_ts_valid(trig_ts_valid), .ts_overrun(ts_overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pad delayed by the synchronizer depth, blanking judged from
  // the last edge local_trig was seen high, qualification as a streak of good samples.
  bit          sq[$];
  int          edge_no = 0;
  int          last_local;
  bit          m_fire;
  int          m_streak, m_hold;
  bit          m_wait;
  int unsigned m_cnt;
  logic [TW-1:0] m_ts;
  bit          m_tsv, m_ovr;

  task automatic model_reset();
    sq.delete();
    for (int i = 0; i < SYNC; i++) sq.push_back(1'b0);
    last_local = -1000;
    m_fire = 0; m_streak = 0; m_hold = 0; m_wait = 0;
    m_cnt = 0; m_ts = '0; m_tsv = 0; m_ovr = 0;
  endtask

  task automatic model_edge();
    bit s;
    bit blk;
    s = sq.pop_front();
    sq.push_back(ext_trig_in);
    blk = local_trig || ((edge_no - last_local) <= EB);
    if (local_trig) last_local = edge_no;
    edge_no++;
    if (m_fire) begin
      if (clear_cnt) m_cnt = 1;
      else if (m_cnt != CMAX) m_cnt = m_cnt + 1;
      if (!m_tsv || ts_ack) begin
        m_ts = ts_in;
        m_tsv = 1;
      end else begin
        m_ovr = 1;
      end
    end else begin
      if (clear_cnt) m_cnt = 0;
      if (ts_ack) m_tsv = 0;
    end
    if (!enable) begin
      m_fire = 0; m_streak = 0; m_hold = 0; m_wait = 0;
    end else if (m_fire) begin
      m_fire = 0;
      if (HO > 0) m_hold = HO;
      else m_wait = 1;
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_wait = 1;
    end else if (m_wait) begin
      if (!s) m_wait = 0;
    end else if (s && !blk) begin
      m_streak++;
      if (m_streak == MW) begin
        m_fire = 1;
        m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
  endtask

  task automatic compare();
    chk("trig_pulse", trig_pulse, m_fire);
    chk("busy", busy, (m_fire || m_hold > 0 || m_wait || m_streak > 0));
    chk("trig_count", trig_count, m_cnt);
    chk("trig_ts_valid", trig_ts_valid, TS_EN ? m_tsv : 1'b0);
    chk("ts_overrun", ts_overrun, TS_EN ? m_ovr : 1'b0);
    chk("trig_ts", trig_ts, TS_EN ? m_ts : '0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    ts_in = {16'($urandom), $urandom};
  endtask

  task automatic hold_in(input bit e, input bit l, input int n);
    ext_trig_in = e;
    local_trig  = l;
    repeat (n) cycle();
  endtask

  // One pad pulse; optionally ack / clear exactly in the model's fire cycle.
  task automatic pulse_ev(input int w, input int gap, input bit ack_f, input bit clr_f);
    for (int i = 0; i < w + gap; i++) begin
      ext_trig_in = (i < w);
      ts_ack      = ack_f & m_fire;
      clear_cnt   = clr_f & m_fire;
      cycle();
    end
    ts_ack = 1'b0;
    clear_cnt = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_pulse"}, trig_pulse, 1'b0);
    chk({pfx, "_busy"}, busy, 1'b0);
    chk({pfx, "_count"}, trig_count, '0);
    chk({pfx, "_ts"}, trig_ts, '0);
    chk({pfx, "_tsv"}, trig_ts_valid, 1'b0);
    chk({pfx, "_ovr"}, ts_overrun, 1'b0);
  endtask

  int unsigned c0;
  int run_left, loc_left, dis_left;
  bit cur;

  initial begin
    model_reset();
    #22;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Clean 10-cycle pulse, then a 3-cycle glitch.
    hold_in(1, 0, 10);
    hold_in(0, 0, 90);
    chk("first_event_count", trig_count, 1);
    hold_in(1, 0, 3);
    hold_in(0, 0, 20);
    chk("glitch_count", trig_count, 1);
    chk("glitch_idle", busy, 1'b0);

    // Echo that ends inside the blanking window is rejected.
    c0 = trig_count;
    hold_in(1, 1, 5);
    hold_in(1, 0, 6);
    hold_in(0, 0, 20);
    chk("echo_rejected", trig_count, c0);
    // Echo tail, then a genuine pulse after blanking expires.
    hold_in(1, 1, 5);
    hold_in(1, 0, 3);
    hold_in(0, 0, 6);
    hold_in(1, 0, 10);
    hold_in(0, 0, 80);
    chk("post_blank_event", trig_count, c0 + 1);

    // Stuck-high level yields a single event; a fresh pulse after release adds one.
    c0 = trig_count;
    hold_in(1, 0, 500);
    hold_in(0, 0, 3);
    hold_in(1, 0, 10);
    hold_in(0, 0, 80);
    chk("stuck_high_events", trig_count, c0 + 2);

    // Disabled receiver ignores a long pulse.
    c0 = trig_count;
    enable = 1'b0;
    hold_in(1, 0, 12);
    hold_in(0, 0, 4);
    enable = 1'b1;
    hold_in(0, 0, 4);
    chk("disabled_no_event", trig_count, c0);

    // Timestamp overrun, then ack coincident with fire.
    ts_ack = 1'b1;
    cycle();
    ts_ack = 1'b0;
    pulse_ev(8, 80, 0, 0);
    pulse_ev(8, 80, 0, 0);
    pulse_ev(8, 80, 1, 0);

    // Saturation then clear coincident with fire.
    for (int i = 0; i < 17; i++) pulse_ev(6, 72, 0, 0);
    chk("saturated", trig_count, CMAX);
    pulse_ev(6, 72, 0, 1);
    chk("clear_on_fire", trig_count, 1);

    // Reset while holding off.
    pulse_ev(6, 12, 0, 0);
    chk("in_hold_busy", busy, 1'b1);
    #2 rst = 1'b1;
    ext_trig_in = 1'b0;
    #1;
    check_all_zero("rst_hold");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic.
    run_left = 0; loc_left = 0; dis_left = 0; cur = 1'b0;
    for (int n = 0; n < 7000; n++) begin
      if (run_left == 0) begin
        cur = ~cur;
        run_left = cur ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 90));
      end
      run_left--;
      if (loc_left == 0 && $urandom_range(0, 199) == 0) loc_left = $urandom_range(1, 6);
      if (dis_left == 0 && $urandom_range(0, 299) == 0) dis_left = $urandom_range(1, 10);
      ext_trig_in = cur;
      local_trig  = (loc_left > 0);
      enable      = (dis_left == 0);
      if (loc_left > 0) loc_left--;
      if (dis_left > 0) dis_left--;
      ts_ack    = ($urandom_range(0, 15) == 0) || (m_fire && $urandom_range(0, 1) == 1);
      clear_cnt = ($urandom_range(0, 499) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
